// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive packet sequencer.
// PID constants are in arrival order (first received bit at [7]).
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PID,
        DATA,
        CRC,
        WAIT_EOP,
        DONE
    } rx_state_t;

    localparam int PID_BITS = 8;
    localparam int CRC_BITS = 16;

    localparam logic [7:0] PID_ACK   = 8'h4B;
    localparam logic [7:0] PID_DATA0 = 8'hC3;

    // Upper nibble must be the bitwise complement of the lower nibble.
    function automatic logic pid_ok(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

endpackage

// File: rtl/usb_rx_packet_sequencer_counter.sv
// Received-bit counter: synchronous clear has priority over enable.
module rx_bit_counter #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/usb_rx_packet_sequencer.sv
// Captures one received USB packet into raw PID/data/CRC registers and holds
// it under a valid/ack handshake, flagging framing and PID-check errors.
//
// state    | meaning
// IDLE     | waiting for rx_start
// PID      | shifting PID bits
// DATA     | shifting payload bits
// CRC      | shifting CRC16 bits
// WAIT_EOP | full data packet received, expecting rx_eop
// DONE     | packet valid, waiting for pkt_ack
module usb_rx_packet_sequencer
    import usb_rx_pkg::*;
#(
    parameter int DATA_BITS = 64
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rx_start,
    input  logic                 bit_valid,
    input  logic                 rx_bit,
    input  logic                 rx_eop,
    input  logic                 pkt_ack,
    output logic [7:0]           pid_raw,
    output logic [DATA_BITS-1:0] data_raw,
    output logic [15:0]          crc_raw,
    output logic                 pkt_valid,
    output logic                 pkt_has_data,
    output logic                 rx_error,
    output logic                 busy
);

    localparam int TOTAL_BITS = PID_BITS + DATA_BITS + CRC_BITS;
    localparam int CNT_MIN    = $clog2(TOTAL_BITS + 1);
    localparam int CNT_W      = (CNT_MIN > 7) ? CNT_MIN : 7;

    localparam logic [CNT_W-1:0] END_PID  = CNT_W'(PID_BITS);
    localparam logic [CNT_W-1:0] END_DATA = CNT_W'(PID_BITS + DATA_BITS);
    localparam logic [CNT_W-1:0] END_CRC  = CNT_W'(TOTAL_BITS);

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     count, count_upd;
    logic                 cnt_clr, cnt_en;
    logic [7:0]           pid_d;
    logic [DATA_BITS-1:0] data_d;
    logic [15:0]          crc_d;
    logic                 has_data_d, error_d;

    rx_bit_counter #(.WIDTH(CNT_W)) u_bit_counter (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    always_comb begin
        state_d    = state_q;
        pid_d      = pid_raw;
        data_d     = data_raw;
        crc_d      = crc_raw;
        has_data_d = pkt_has_data;
        error_d    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        count_upd  = count;

        unique case (state_q)
            IDLE: begin
                if (rx_start) begin
                    state_d    = PID;
                    cnt_clr    = 1'b1;
                    pid_d      = '0;
                    data_d     = '0;
                    crc_d      = '0;
                    has_data_d = 1'b0;
                end
            end
            PID, DATA, CRC, WAIT_EOP: begin
                if (rx_start) begin
                    error_d    = 1'b1;
                    state_d    = PID;
                    cnt_clr    = 1'b1;
                    pid_d      = '0;
                    data_d     = '0;
                    crc_d      = '0;
                    has_data_d = 1'b0;
                end else begin
                    // The bit is taken first so a coincident rx_eop sees the new count.
                    if (bit_valid) begin
                        cnt_en    = 1'b1;
                        count_upd = count + CNT_W'(1);
                        case (state_q)
                            PID:     pid_d  = {pid_raw[6:0], rx_bit};
                            DATA:    data_d = {data_raw[DATA_BITS-2:0], rx_bit};
                            CRC:     crc_d  = {crc_raw[14:0], rx_bit};
                            default: ;
                        endcase
                        if (state_q == WAIT_EOP) begin
                            error_d = 1'b1;
                            state_d = IDLE;
                        end else if (state_q == PID && count_upd == END_PID) begin
                            state_d = DATA;
                        end else if (state_q == DATA && count_upd == END_DATA) begin
                            state_d = CRC;
                        end else if (state_q == CRC && count_upd == END_CRC) begin
                            state_d = WAIT_EOP;
                        end
                    end
                    if (rx_eop && state_d != IDLE) begin
                        if ((count_upd == END_PID || count_upd == END_CRC) && pid_ok(pid_d)) begin
                            state_d    = DONE;
                            has_data_d = (count_upd == END_CRC);
                        end else begin
                            error_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            DONE: begin
                error_d = rx_start;
                if (pkt_ack) begin
                    state_d    = IDLE;
                    has_data_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            pid_raw      <= '0;
            data_raw     <= '0;
            crc_raw      <= '0;
            pkt_valid    <= 1'b0;
            pkt_has_data <= 1'b0;
            rx_error     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            pid_raw      <= pid_d;
            data_raw     <= data_d;
            crc_raw      <= crc_d;
            pkt_valid    <= (state_d == DONE);
            pkt_has_data <= has_data_d;
            rx_error     <= error_d;
            busy         <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_usb_rx_packet_sequencer.sv
// Randomized bench for usb_rx_packet_sequencer with a packet-level reference model.
module tb_usb_rx_packet_sequencer;

    localparam int DB    = 64;
    localparam int TOTAL = 8 + DB + 16;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          rx_start, bit_valid, rx_bit, rx_eop, pkt_ack;
    logic [7:0]    pid_raw;
    logic [DB-1:0] data_raw;
    logic [15:0]   crc_raw;
    logic          pkt_valid, pkt_has_data, rx_error, busy;

    int checks = 0;
    int errors = 0;

    bit pkt_bits[$];

    usb_rx_packet_sequencer #(.DATA_BITS(DB)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .rx_start     (rx_start),
        .bit_valid    (bit_valid),
        .rx_bit       (rx_bit),
        .rx_eop       (rx_eop),
        .pkt_ack      (pkt_ack),
        .pid_raw      (pid_raw),
        .data_raw     (data_raw),
        .crc_raw      (crc_raw),
        .pkt_valid    (pkt_valid),
        .pkt_has_data (pkt_has_data),
        .rx_error     (rx_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a packet is accepted when it ends after exactly the PID
    // or after the full data packet, and its PID nibbles are complementary.
    function automatic bit model_accept(input int n, input logic [7:0] p);
        int hi, lo;
        hi = int'(p) / 16;
        lo = int'(p) % 16;
        return (n == 8 || n == TOTAL) && (hi == 15 - lo);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        rx_start = 1'b1;
        cyc();
        rx_start = 1'b0;
    endtask

    task automatic pulse_eop();
        rx_eop = 1'b1;
        cyc();
        rx_eop = 1'b0;
    endtask

    task automatic pulse_ack();
        pkt_ack = 1'b1;
        cyc();
        pkt_ack = 1'b0;
    endtask

    // Arrival order: each field goes out most-significant bit first.
    task automatic build_packet(input logic [7:0] p, input logic [DB-1:0] d,
                                input logic [15:0] c, input int nbits);
        pkt_bits.delete();
        for (int i = 0; i < 8; i++)  pkt_bits.push_back(p[7-i]);
        for (int i = 0; i < DB; i++) pkt_bits.push_back(d[DB-1-i]);
        for (int i = 0; i < 16; i++) pkt_bits.push_back(c[15-i]);
        while (pkt_bits.size() > nbits) void'(pkt_bits.pop_back());
    endtask

    task automatic send_bits(input bit gaps, input bit eop_last);
        for (int i = 0; i < pkt_bits.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) cyc();
            bit_valid = 1'b1;
            rx_bit    = pkt_bits[i];
            rx_eop    = eop_last && (i == pkt_bits.size() - 1);
            cyc();
            bit_valid = 1'b0;
            rx_eop    = 1'b0;
        end
    endtask

    task automatic test_reset();
        if (pid_raw !== 8'h00) begin errors++; $display("FAIL reset_pid: got %h want 00", pid_raw); end
        checks++;
        if (data_raw !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data_raw); end
        checks++;
        if (crc_raw !== 16'h0) begin errors++; $display("FAIL reset_crc: got %h want 0", crc_raw); end
        checks++;
        if ({pkt_valid, pkt_has_data, rx_error, busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {pkt_valid, pkt_has_data, rx_error, busy});
        end
        checks++;
    endtask

    task automatic test_ack();
        logic [7:0] seq;
        pulse_ack();
        if (busy !== 1'b0 || pkt_valid !== 1'b0) begin
            errors++; $display("FAIL idle_ack: busy=%b valid=%b want 0 0", busy, pkt_valid);
        end
        checks++;
        pulse_start();
        if (busy !== 1'b1) begin errors++; $display("FAIL ack_busy: got %b want 1", busy); end
        checks++;
        seq = 8'b0100_1011;
        pkt_bits.delete();
        for (int i = 7; i >= 0; i--) pkt_bits.push_back(seq[i]);
        send_bits(1'b1, 1'b0);
        if (pkt_valid !== 1'b0) begin errors++; $display("FAIL ack_early_valid: got %b want 0", pkt_valid); end
        checks++;
        pulse_eop();
        if (pkt_valid !== 1'b1 || pkt_has_data !== 1'b0 || rx_error !== 1'b0) begin
            errors++; $display("FAIL ack_result: valid=%b has_data=%b err=%b want 1 0 0", pkt_valid, pkt_has_data, rx_error);
        end
        checks++;
        if (pid_raw !== 8'h4B) begin errors++; $display("FAIL ack_pid: got %h want 4b", pid_raw); end
        checks++;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (pkt_valid !== 1'b1) begin errors++; $display("FAIL ack_hold: cycle %0d got %b want 1", k, pkt_valid); end
            checks++;
        end
        pulse_ack();
        if (pkt_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL ack_release: valid=%b busy=%b want 0 0", pkt_valid, busy);
        end
        checks++;
    endtask

    task automatic test_data_packets();
        logic [DB-1:0] d;
        logic [15:0]   c;
        bit            gaps;
        for (int n = 0; n < 4; n++) begin
            d    = {$urandom, $urandom};
            c    = 16'($urandom);
            gaps = (n >= 2);
            build_packet(8'hC3, d, c, TOTAL);
            pulse_start();
            send_bits(gaps, 1'b0);
            pulse_eop();
            if (pkt_valid !== 1'b1 || pkt_has_data !== 1'b1 || rx_error !== 1'b0) begin
                errors++; $display("FAIL data%0d_flags: valid=%b has_data=%b err=%b want 1 1 0", n, pkt_valid, pkt_has_data, rx_error);
            end
            checks++;
            if (pid_raw !== 8'hC3 || data_raw !== d || crc_raw !== c) begin
                errors++; $display("FAIL data%0d_regs: pid=%h data=%h crc=%h want c3 %h %h", n, pid_raw, data_raw, crc_raw, d, c);
            end
            checks++;
            pulse_ack();
            if (pkt_valid !== 1'b0) begin errors++; $display("FAIL data%0d_ack: got %b want 0", n, pkt_valid); end
            checks++;
        end
    endtask

    task automatic test_bad_pid();
        logic [7:0] p;
        bit         acc;
        build_packet(8'hC4, '0, '0, 8);
        pulse_start();
        send_bits(1'b0, 1'b0);
        pulse_eop();
        if (rx_error !== 1'b1 || pkt_valid !== 1'b0) begin
            errors++; $display("FAIL badpid_err: err=%b valid=%b want 1 0", rx_error, pkt_valid);
        end
        checks++;
        cyc();
        if (rx_error !== 1'b0 || busy !== 1'b0 || pkt_valid !== 1'b0) begin
            errors++; $display("FAIL badpid_after: err=%b busy=%b valid=%b want 0 0 0", rx_error, busy, pkt_valid);
        end
        checks++;
        for (int n = 0; n < 8; n++) begin
            p   = (n % 2 == 0) ? 8'($urandom) : {~4'($urandom_range(0, 15) ^ 4'hF), 4'h0};
            if (n % 2 == 1) p[3:0] = ~p[7:4];
            acc = model_accept(8, p);
            build_packet(p, '0, '0, 8);
            pulse_start();
            send_bits(1'b1, 1'b0);
            pulse_eop();
            if (pkt_valid !== acc || rx_error !== !acc) begin
                errors++; $display("FAIL randpid_%h: valid=%b err=%b want %b %b", p, pkt_valid, rx_error, acc, !acc);
            end
            checks++;
            if (acc) pulse_ack(); else cyc();
        end
    endtask

    task automatic test_framing();
        int         n;
        bit         acc;
        logic [7:0] p;
        logic [DB-1:0] d;
        build_packet(8'hC3, {$urandom, $urandom}, 16'hBEEF, 40);
        pulse_start();
        send_bits(1'b0, 1'b0);
        pulse_eop();
        if (rx_error !== 1'b1 || pkt_valid !== 1'b0) begin
            errors++; $display("FAIL eop40: err=%b valid=%b want 1 0", rx_error, pkt_valid);
        end
        checks++;
        cyc();

        build_packet(8'hC3, {$urandom, $urandom}, 16'h1234, TOTAL);
        pkt_bits.push_back(1'b1);
        pulse_start();
        send_bits(1'b0, 1'b0);
        if (rx_error !== 1'b1) begin errors++; $display("FAIL overlength: err=%b want 1", rx_error); end
        checks++;
        cyc();
        if (rx_error !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL overlength_after: err=%b busy=%b want 0 0", rx_error, busy);
        end
        checks++;
        pulse_eop();
        if (rx_error !== 1'b0 || pkt_valid !== 1'b0) begin
            errors++; $display("FAIL idle_eop: err=%b valid=%b want 0 0", rx_error, pkt_valid);
        end
        checks++;

        d = {$urandom, $urandom};
        build_packet(8'hC3, d, 16'hA5C3, TOTAL);
        pulse_start();
        send_bits(1'b0, 1'b1);
        if (pkt_valid !== 1'b1 || rx_error !== 1'b0 || pkt_has_data !== 1'b1 || data_raw !== d) begin
            errors++; $display("FAIL eop_with_bit88: valid=%b err=%b has_data=%b data=%h want 1 0 1 %h", pkt_valid, rx_error, pkt_has_data, data_raw, d);
        end
        checks++;
        pulse_ack();

        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0:       n = 8;
                1:       n = TOTAL;
                default: n = $urandom_range(1, TOTAL);
            endcase
            p   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hC3;
            acc = model_accept(n, p);
            build_packet(p, {$urandom, $urandom}, 16'($urandom), n);
            pulse_start();
            send_bits(1'b1, 1'b0);
            pulse_eop();
            if (pkt_valid !== acc || rx_error !== !acc || (acc && pkt_has_data !== (n == TOTAL))) begin
                errors++; $display("FAIL frame_n%0d_pid%h: valid=%b err=%b has_data=%b want acc=%b", n, p, pkt_valid, rx_error, pkt_has_data, acc);
            end
            checks++;
            if (acc) pulse_ack(); else cyc();
        end
    endtask

    task automatic test_overrun_restart();
        logic [DB-1:0] d;
        logic [15:0]   c;
        d = {$urandom, $urandom};
        c = 16'($urandom);
        build_packet(8'hC3, d, c, TOTAL);
        pulse_start();
        send_bits(1'b1, 1'b0);
        pulse_eop();
        pulse_start();
        if (rx_error !== 1'b1 || pkt_valid !== 1'b1) begin
            errors++; $display("FAIL overrun_err: err=%b valid=%b want 1 1", rx_error, pkt_valid);
        end
        checks++;
        cyc();
        if (rx_error !== 1'b0 || pkt_valid !== 1'b1 || pkt_has_data !== 1'b1 ||
            pid_raw !== 8'hC3 || data_raw !== d || crc_raw !== c) begin
            errors++; $display("FAIL overrun_keep: err=%b valid=%b pid=%h data=%h crc=%h want 0 1 c3 %h %h", rx_error, pkt_valid, pid_raw, data_raw, crc_raw, d, c);
        end
        checks++;
        pulse_ack();

        build_packet(8'hC3, {$urandom, $urandom}, 16'($urandom), 20);
        pulse_start();
        send_bits(1'b0, 1'b0);
        pulse_start();
        if (rx_error !== 1'b1 || busy !== 1'b1 || pid_raw !== 8'h00) begin
            errors++; $display("FAIL restart_err: err=%b busy=%b pid=%h want 1 1 00", rx_error, busy, pid_raw);
        end
        checks++;
        d = {$urandom, $urandom};
        c = 16'($urandom);
        build_packet(8'hC3, d, c, TOTAL);
        send_bits(1'b1, 1'b0);
        pulse_eop();
        if (pkt_valid !== 1'b1 || rx_error !== 1'b0 || data_raw !== d || crc_raw !== c || pid_raw !== 8'hC3) begin
            errors++; $display("FAIL restart_capture: valid=%b err=%b pid=%h data=%h crc=%h want 1 0 c3 %h %h", pkt_valid, rx_error, pid_raw, data_raw, crc_raw, d, c);
        end
        checks++;
        pulse_ack();
    endtask

    task automatic test_reset_mid_packet();
        build_packet(8'hC3, {$urandom | 32'h1, $urandom | 32'h1}, 16'hFFFF, 50);
        pulse_start();
        send_bits(1'b0, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        if ({pid_raw, data_raw, crc_raw, pkt_valid, pkt_has_data, rx_error, busy} !== '0) begin
            errors++; $display("FAIL reset_mid: pid=%h data=%h crc=%h flags=%b want all 0", pid_raw, data_raw, crc_raw, {pkt_valid, pkt_has_data, rx_error, busy});
        end
        checks++;
        cyc();
        n_rst = 1'b1;
        cyc();
        if (rx_error !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: err=%b busy=%b want 0 0", rx_error, busy);
        end
        checks++;
        build_packet(8'h4B, '0, '0, 8);
        pulse_start();
        send_bits(1'b1, 1'b0);
        pulse_eop();
        if (pkt_valid !== 1'b1 || pkt_has_data !== 1'b0 || pid_raw !== 8'h4B) begin
            errors++; $display("FAIL reset_ack_pkt: valid=%b has_data=%b pid=%h want 1 0 4b", pkt_valid, pkt_has_data, pid_raw);
        end
        checks++;
        pulse_ack();
    endtask

    initial begin
        n_rst     = 1'b0;
        rx_start  = 1'b0;
        bit_valid = 1'b0;
        rx_bit    = 1'b0;
        rx_eop    = 1'b0;
        pkt_ack   = 1'b0;
        repeat (3) cyc();
        test_reset();
        n_rst = 1'b1;
        cyc();
        test_ack();
        test_data_packets();
        test_bad_pid();
        test_framing();
        test_overrun_restart();
        test_reset_mid_packet();
        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
